instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage that drives the read side of the `rom` block and supplies 32-bit instruction words, each tagged with its PC, to the decode stage through a valid/ready handshake. It keeps one ROM read in flight per cycle for full throughput and absorbs decode back-pressure in a 2-entry buffer. It also handles branch redirects with a full flush, and faults on any PC outside the ROM window. The ROM write path (`write_enable`/`data_in`) belongs to the loader, not this block.

## Interface
- `ROM_BASE`, default 32'h08000000: first byte address of the ROM window.
- `ROM_SIZE`, default 32'h00100000: window size in bytes, 1 MiB. Valid PCs lie in [ROM_BASE, ROM_BASE+ROM_SIZE).
- `RESET_PC`, default 32'h08000000: PC loaded at reset.
- `clock`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rom_address`  out  32  connects to ROM `address`. ROM registers `data_out` at the edge where the address is sampled.
- `rom_data`  in  32  ROM `data_out`, valid in the cycle after the issue edge.
- `branch_valid`  in  1  redirect request, one-cycle pulse.
- `branch_target`  in  32  redirect PC.
- `instr_valid`  out  1  buffer head valid.
- `instr`  out  32  instruction word.
- `instr_pc`  out  32  PC of `instr`.
- `instr_ready`  in  1  decode accepts the head.
- `fetch_fault`  out  1  fetch halted on a bad PC.
- `fetch_count`, `stall_count`  out  32 each  perf counters; see Configuration.

## Operation
- State machine: RUN and FAULT. Reset enters RUN.
- Registers:
  - `pc`: next address to issue.
  - `inflight`: 1 bit, plus `inflight_pc`.
  - 2-entry FIFO of {pc, word}, with occupancy `count` from 0 to 2.
- `rom_address` = `pc` at all times.
- Issue condition: state RUN, `pc` in range, `pc[1:0]`==0, and (`count`+`inflight` < 2 or a pop occurs this cycle).
  - On issue: `pc` <= `pc`+4, `inflight` <= 1, `inflight_pc` <= `pc`.
  - With no issue: `inflight` <= 0.
- Capture: if `inflight`, push {`inflight_pc`, `rom_data`} into the FIFO at the edge. The credit rule guarantees no overflow.
- Pop: `instr_valid` && `instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- `instr_valid` = (`count` != 0). `instr`/`instr_pc` show the FIFO head and hold stable while valid and not ready.
- Fault: in RUN, if `pc` is out of range or misaligned, go to FAULT with no issue.
  - `fetch_fault` = 1 while in FAULT.
  - Entries already buffered and in flight still drain to decode.
- Branch, highest priority, accepted in RUN or FAULT:
  - FIFO flushes (`count` <= 0) and `inflight` <= 0; the in-flight word is discarded.
  - A pop in the same cycle still completes, because decode sampled it.
  - `pc` <= `branch_target`; state <= RUN.
  - No issue occurs in the branch cycle.
  - A bad target faults on the following cycle.
- Address arithmetic is 32-bit; `pc`+4 wraps modulo 2^32. `pc` = 0x080FFFFC issues, and the resulting 0x08100000 faults.

## Timing
- Reset values:
  - `pc` = RESET_PC; `rom_address` = RESET_PC.
  - `inflight` = 0, `count` = 0.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, `fetch_fault` = 0.
  - Counters = 0; state RUN.
- Reset mid-operation clears everything asynchronously; an in-flight word is never captured.
- Latency: issue at edge E, data capture at E+1, `instr_valid` high in the cycle after E+1.
  - First instruction after reset deassertion: `instr_valid` on the 2nd cycle after the first active edge.
- Branch at edge B: target issues at B+1, and `instr_valid` for the target rises after B+2. Two-cycle bubble.
- Steady state with `instr_ready`=1: one instruction per cycle.
- With `instr_ready`=0: at most 2 buffered entries; issue stops once `count`+`inflight` = 2.

## Configuration
- Macro `FETCH_PERF_COUNT_EN`.
- Defined:
  - `fetch_count` increments on every push.
  - `stall_count` increments each cycle with `instr_valid`=1 and `instr_ready`=0.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter registers are built.

## Test plan
- Reset, ROM preloaded 0x08000000=0x01234567, 0x08000004=0xE3A00001, `instr_ready`=1 -> 0x01234567 with `instr_pc`=0x08000000, then 0xE3A00001/0x08000004 on consecutive cycles.
- Hold `instr_ready`=0 for 5 cycles after the first valid -> `instr` stays 0x01234567, `rom_address` freezes at 0x08000008, and `stall_count`=5 when the macro is on. Release -> 0x08000004 then 0x08000008 with no gap and no duplicate.
- `branch_valid` with target 0x08000100 while the FIFO holds 2 entries -> `instr_valid` drops next cycle, and the next delivered `instr_pc`=0x08000100 after 2 bubble cycles.
- Branch to 0x080FFFFC -> the word at 0x080FFFFC is delivered, then `fetch_fault`=1 and `rom_address` holds 0x08100000.
- Branch to 0x08000002 -> `fetch_fault`=1 with no delivery. A further branch to 0x08000000 clears the fault and resumes fetch.
- Assert `reset` while an entry is in flight and 1 is buffered -> `instr_valid`=0 immediately and `rom_address`=0x08000000; after release the first delivered `instr_pc`=0x08000000.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: ROM read issue, 2-entry decode buffer, branch flush, range fault. Optional perf counters under FETCH_PERF_COUNT_EN.
module instr_fetch #(
    parameter logic [31:0] ROM_BASE = 32'h0800_0000,
    parameter logic [31:0] ROM_SIZE = 32'h0010_0000,
    parameter logic [31:0] RESET_PC = 32'h0800_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_fault,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_word_q [2];
    logic [31:0] fifo_word_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic [31:0] pc_offset;
    logic        pc_ok;
    logic [1:0]  occupancy;
    logic        credit_ok;
    logic        issue;
    logic        push;
    logic        pop;

    // The ROM always sees the next PC; it only matters on cycles where we issue.
    assign rom_address = pc_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = instr_valid ? fifo_word_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign fetch_fault = (state_q == ST_FAULT);

    // Issue/capture/pop decisions; subtracting the base makes the window check wrap-safe.
    always_comb begin
        pc_offset = pc_q - ROM_BASE;
        pc_ok     = (pc_offset < ROM_SIZE) && (pc_q[1:0] == 2'b00);
        occupancy = count_q + {1'b0, inflight_q};
        pop       = instr_valid && instr_ready;
        credit_ok = (occupancy < 2'd2) || pop;
        issue     = (state_q == ST_RUN) && !branch_valid && pc_ok && credit_ok;
        push      = inflight_q && !branch_valid;
    end

    // Next-state for PC, in-flight tracking, buffer and FSM; a branch overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        for (int i = 0; i < 2; i++) begin
            fifo_pc_d[i]   = fifo_pc_q[i];
            fifo_word_d[i] = fifo_word_q[i];
        end

        if (branch_valid) begin
            // Flush: the in-flight word is dropped; a same-cycle pop is already consumed by decode.
            pc_d     = branch_target;
            state_d  = ST_RUN;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
                fifo_word_d[wr_ptr_q] = rom_data;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if ((state_q == ST_RUN) && !pc_ok) begin
                state_d = ST_FAULT;
            end
        end
    end

    // Fetch state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= 32'h0;
                fifo_word_q[i] <= 32'h0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]   <= fifo_pc_d[i];
                fifo_word_q[i] <= fifo_word_d[i];
            end
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;

    // Count captured words and cycles where decode holds off a valid head.
    always_comb begin
        fetch_count_d = fetch_count_q + {31'h0, push};
        stall_count_d = stall_count_q + {31'h0, (instr_valid && !instr_ready)};
    end

    // Performance counter registers, free-running and wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end
`else
    assign fetch_count = 32'h0;
    assign stall_count = 32'h0;
`endif

endmodule
